nv_nvdla_pdp_pool1d_lane: RTL and testbench
===========================================

NV_NVDLA_PDP_POOL1D_LANE -- requirements
Module: nv_nvdla_pdp_pool1d_lane

Interface
REQ-001 Parameter LANES, default 1: elements per beat, each pooled independently with shared control.
REQ-002 Parameter DW, default 8: signed element width.
REQ-003 Parameter KMAX, default 8: maximum kernel width and number of concurrent window slots.
REQ-004 nvdla_core_clk  in  1  single clock.
REQ-005 nvdla_core_rstn  in  1  asynchronous active-low reset.
REQ-006 cfg_kernel_width  in  3  kernel K = value+1 (1..KMAX).
REQ-007 cfg_stride  in  4  stride S = value+1; legal only with S <= K.
REQ-008 cfg_pool_type  in  2  0=sum (avg pre-divide), 1=max, 2=min; 3 reserved, behaves as sum.
REQ-009 cfg_line_width  in  13  input pixels per line W = value+1.
REQ-010 cfg_pad_left, cfg_pad_right  in  3 each  pad pixels PL/PR; only with the pad macro.
REQ-011 cfg_pad_value  in  DW+3  signed pad value; only with the pad macro.
REQ-012 pre2pool_pvld/pre2pool_prdy  in/out  1/1  input handshake.
REQ-013 pre2pool_pd  in  LANES*DW  lane i at bits [i*DW +: DW].
REQ-014 pool2out_pvld/pool2out_prdy  out/in  1/1  output handshake.
REQ-015 pool2out_pd  out  LANES*(DW+3)  lane i at [i*(DW+3) +: DW+3].
REQ-016 busy  out  1  high from the first accepted beat of a line until its last output is accepted.

Function
REQ-017 FSM states: IDLE, PAD_L, DATA, PAD_R, DRAIN; configuration is sampled on the IDLE exit and held for the whole line.
REQ-018 IDLE->PAD_L if PL>0, else IDLE->DATA, on the first pre2pool_pvld.
REQ-019 PAD_L/PAD_R process one virtual pixel per cycle, gated by output-slot availability.
REQ-020 DATA accepts exactly W beats; then DATA->PAD_R if PR>0, else ->DRAIN.
REQ-021 DRAIN->IDLE once pool2out holds no unaccepted result; pre2pool_prdy is low in PAD_L, PAD_R and DRAIN.
REQ-022 Virtual pixel index p (0..PL+W+PR-1) contributes to every window j with j*S <= p <= j*S+K-1.
REQ-023 At most ceil(K/S) windows are open at once; they are held in a KMAX-entry circular slot array.
REQ-024 A slot opens at p=j*S, initialised from that pixel, and closes at p=j*S+K-1.
REQ-025 Outputs per line = floor((PL+W+PR-K)/S)+1 when K <= PL+W+PR, else 0; windows not fully covered are discarded.
REQ-026 Sum: signed DW+3-bit accumulate; inputs sign-extended; no saturation needed (K<=8).
REQ-027 Max/min: signed compare; result sign-extended to DW+3; pad pixels are ignored.
REQ-028 Pad pixels add cfg_pad_value in sum mode.
REQ-029 A closing window loads a single output register; pool2out_pvld rises the cycle after the closing pixel is processed (latency 1).
REQ-030 pre2pool_prdy (in DATA) = !pool2out_pvld | pool2out_prdy; a pixel is processed only in that condition, so no result is lost.
REQ-031 pool2out_pd is stable while pool2out_pvld & !pool2out_prdy.
REQ-032 Back-to-back lines: DRAIN->DATA/PAD_L directly when a new pvld arrives and the output is drained, with no bubble.

Reset
REQ-033 On nvdla_core_rstn low, at any time including mid-line: FSM->IDLE, slots and counters cleared, pool2out_pvld=0, pool2out_pd=0, pre2pool_prdy=0, busy=0; a partial line is lost.
REQ-034 pre2pool_prdy rises no earlier than the first clock after reset release.

Configuration
REQ-035 Macro NVDLA_PDP_POOL1D_PAD_EN: when defined, padding ports and the PAD_L/PAD_R states exist.
REQ-036 Without NVDLA_PDP_POOL1D_PAD_EN: the padding ports are absent, PL=PR=0, and PAD_L/PAD_R are unreachable.

Verification (LANES=1, DW=8)
REQ-037 max, K=3, S=1, W=5, in 1,5,2,7,3 -> out 5,7,7, then busy=0.
REQ-038 sum, K=2, S=2, W=4, in -1,3,4,4 -> out 2,8, with pd=11'h002 and 11'h008.
REQ-039 min, K=3, S=2, W=7, in 9,4,6,-3,8,2,5, pool2out_prdy low 3 cycles mid-line -> out 4,-3,2, no loss, pd stable while stalled.
REQ-040 PAD_EN: sum, K=3, S=1, PL=PR=1, pad=2, in 1,2,3 -> out 5,6,7.
REQ-041 K=4, W=3, sum -> 3 beats accepted, 0 outputs, FSM returns to IDLE.
REQ-042 Reset asserted after 2 of 5 beats, then a fresh line max K=2, S=1 with in 1,2,3 -> out 2,3, with no stale output.

Source files
------------

// File: rtl/nv_nvdla_pdp_pool1d_lane_if.sv
// Valid/ready/payload bundle for the 1-D pooling lane.
// A master drives pvld/pd and the slave returns prdy.
interface nv_nvdla_pdp_pool1d_lane_if #(
    parameter int unsigned PW = 8
);
    logic          pvld;
    logic          prdy;
    logic [PW-1:0] pd;

    modport master (output pvld, output pd, input prdy);
    modport slave  (input pvld, input pd, output prdy);
endinterface

// File: rtl/nv_nvdla_pdp_pool1d_lane.sv
// 1-D sliding-window pooling (sum/max/min) over one line of LANES-wide beats.
// Optional left/right padding is enabled by defining NVDLA_PDP_POOL1D_PAD_EN.
module nv_nvdla_pdp_pool1d_lane #(
    parameter int unsigned LANES = 1,
    parameter int unsigned DW    = 8,
    parameter int unsigned KMAX  = 8
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic [2:0]             cfg_kernel_width,
    input  logic [3:0]             cfg_stride,
    input  logic [1:0]             cfg_pool_type,
    input  logic [12:0]            cfg_line_width,
`ifdef NVDLA_PDP_POOL1D_PAD_EN
    input  logic [2:0]             cfg_pad_left,
    input  logic [2:0]             cfg_pad_right,
    input  logic [DW+2:0]          cfg_pad_value,
`endif
    nv_nvdla_pdp_pool1d_lane_if.slave  pre2pool,
    nv_nvdla_pdp_pool1d_lane_if.master pool2out,
    output logic                   busy
);
    localparam int unsigned OW = DW + 3;
    localparam int unsigned SW = (KMAX > 1) ? $clog2(KMAX) : 1;

    typedef enum logic [2:0] {StIdle, StPadL, StData, StPadR, StDrain} state_e;
    typedef logic [LANES-1:0][OW-1:0] vec_t;

    logic [2:0]    pl_in, pr_in;
    logic [OW-1:0] pad_in;
`ifdef NVDLA_PDP_POOL1D_PAD_EN
    assign pl_in  = cfg_pad_left;
    assign pr_in  = cfg_pad_right;
    assign pad_in = cfg_pad_value;
`else
    assign pl_in  = '0;
    assign pr_in  = '0;
    assign pad_in = '0;
`endif

    state_e             state_q, state_d;
    logic [2:0]         kw_q, kw_d, pl_q, pl_d, pr_q, pr_d;
    logic [3:0]         st_q, st_d, s_cnt_q, s_cnt_d;
    logic [1:0]         pt_q, pt_d;
    logic [12:0]        lw_q, lw_d, cnt_q, cnt_d;
    logic [OW-1:0]      pad_q, pad_d;
    logic [SW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [KMAX-1:0]    slot_vld_q, slot_vld_d, slot_seen_q, slot_seen_d, close_v;
    logic [KMAX-1:0][2:0] slot_cnt_q, slot_cnt_d;
    vec_t [KMAX-1:0]    slot_acc_q, slot_acc_d;
    logic               out_vld_q, out_vld_d;
    vec_t               out_pd_q, out_pd_d;

    logic out_free, proc, is_pad, skip, start, in_prdy, opening;
    vec_t pix;

    function automatic logic [OW-1:0] combine(input logic [OW-1:0] acc, input logic [OW-1:0] px,
                                              input logic seen, input logic skp,
                                              input logic [1:0] pt);
        logic [OW-1:0] r;
        unique case (pt)
            2'd1:    r = skp ? acc : (!seen ? px : (($signed(px) > $signed(acc)) ? px : acc));
            2'd2:    r = skp ? acc : (!seen ? px : (($signed(px) < $signed(acc)) ? px : acc));
            default: r = acc + px;
        endcase
        return r;
    endfunction

    assign out_free      = ~out_vld_q | pool2out.prdy;
    assign pre2pool.prdy = in_prdy;
    assign pool2out.pvld = out_vld_q;
    assign pool2out.pd   = out_pd_q;
    assign busy          = (state_q != StIdle);
    assign opening       = (s_cnt_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        kw_d        = kw_q;
        st_d        = st_q;
        pt_d        = pt_q;
        lw_d        = lw_q;
        pl_d        = pl_q;
        pr_d        = pr_q;
        pad_d       = pad_q;
        cnt_d       = cnt_q;
        s_cnt_d     = s_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        slot_vld_d  = slot_vld_q;
        slot_seen_d = slot_seen_q;
        slot_cnt_d  = slot_cnt_q;
        slot_acc_d  = slot_acc_q;
        close_v     = '0;
        out_vld_d   = out_vld_q & ~pool2out.prdy;
        out_pd_d    = out_pd_q;
        in_prdy     = 1'b0;
        proc        = 1'b0;
        is_pad      = 1'b1;
        start       = 1'b0;

        unique case (state_q)
            StIdle: start = pre2pool.pvld;
            StPadL: begin
                proc = out_free;
                if (proc) begin
                    if (cnt_q == {10'd0, pl_q} - 13'd1) begin
                        cnt_d   = '0;
                        state_d = StData;
                    end else begin
                        cnt_d = cnt_q + 13'd1;
                    end
                end
            end
            StData: begin
                in_prdy = out_free;
                is_pad  = 1'b0;
                proc    = pre2pool.pvld & out_free;
                if (proc) begin
                    if (cnt_q == lw_q) begin
                        cnt_d   = '0;
                        state_d = (pr_q != 3'd0) ? StPadR : StDrain;
                    end else begin
                        cnt_d = cnt_q + 13'd1;
                    end
                end
            end
            StPadR: begin
                proc = out_free;
                if (proc) begin
                    if (cnt_q == {10'd0, pr_q} - 13'd1) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + 13'd1;
                    end
                end
            end
            StDrain: begin
                if (out_free) begin
                    if (pre2pool.pvld) start = 1'b1;
                    else               state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Configuration is captured only when a new line begins.
        if (start) begin
            kw_d    = cfg_kernel_width;
            st_d    = cfg_stride;
            pt_d    = cfg_pool_type;
            lw_d    = cfg_line_width;
            pl_d    = pl_in;
            pr_d    = pr_in;
            pad_d   = pad_in;
            cnt_d   = '0;
            state_d = (pl_in != 3'd0) ? StPadL : StData;
        end

        // Windows left partially covered at line end are discarded here.
        if (state_q == StIdle || state_q == StDrain) begin
            slot_vld_d = '0;
            s_cnt_d    = '0;
            wr_ptr_d   = '0;
        end

        for (int l = 0; l < LANES; l++) begin
            pix[l] = is_pad ? pad_q
                            : {{3{pre2pool.pd[l*DW+DW-1]}}, pre2pool.pd[l*DW +: DW]};
        end
        skip = is_pad & ((pt_q == 2'd1) | (pt_q == 2'd2));

        if (proc) begin
            if (opening) begin
                s_cnt_d  = st_q;
                wr_ptr_d = (wr_ptr_q == SW'(KMAX - 1)) ? '0 : wr_ptr_q + 1'b1;
            end else begin
                s_cnt_d = s_cnt_q - 4'd1;
            end
            for (int i = 0; i < KMAX; i++) begin
                if (opening && wr_ptr_q == SW'(i)) begin
                    slot_vld_d[i]  = 1'b1;
                    slot_cnt_d[i]  = '0;
                    slot_seen_d[i] = ~skip;
                    slot_acc_d[i]  = skip ? '0 : pix;
                    close_v[i]     = (kw_q == 3'd0);
                end else if (slot_vld_q[i]) begin
                    slot_cnt_d[i]  = slot_cnt_q[i] + 3'd1;
                    slot_seen_d[i] = slot_seen_q[i] | ~skip;
                    for (int l = 0; l < LANES; l++) begin
                        slot_acc_d[i][l] = combine(slot_acc_q[i][l], pix[l], slot_seen_q[i],
                                                   skip, pt_q);
                    end
                    close_v[i] = (slot_cnt_q[i] + 3'd1 == kw_q);
                end
                if (close_v[i]) begin
                    slot_vld_d[i] = 1'b0;
                    out_vld_d     = 1'b1;
                    out_pd_d      = slot_acc_d[i];
                end
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q     <= StIdle;
            kw_q        <= '0;
            st_q        <= '0;
            pt_q        <= '0;
            lw_q        <= '0;
            pl_q        <= '0;
            pr_q        <= '0;
            pad_q       <= '0;
            cnt_q       <= '0;
            s_cnt_q     <= '0;
            wr_ptr_q    <= '0;
            slot_vld_q  <= '0;
            slot_seen_q <= '0;
            slot_cnt_q  <= '0;
            slot_acc_q  <= '0;
            out_vld_q   <= 1'b0;
            out_pd_q    <= '0;
        end else begin
            state_q     <= state_d;
            kw_q        <= kw_d;
            st_q        <= st_d;
            pt_q        <= pt_d;
            lw_q        <= lw_d;
            pl_q        <= pl_d;
            pr_q        <= pr_d;
            pad_q       <= pad_d;
            cnt_q       <= cnt_d;
            s_cnt_q     <= s_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            slot_vld_q  <= slot_vld_d;
            slot_seen_q <= slot_seen_d;
            slot_cnt_q  <= slot_cnt_d;
            slot_acc_q  <= slot_acc_d;
            out_vld_q   <= out_vld_d;
            out_pd_q    <= out_pd_d;
        end
    end
endmodule

// File: tb/tb_nv_nvdla_pdp_pool1d_lane.sv
// Table-driven bench for nv_nvdla_pdp_pool1d_lane (LANES=1, DW=8) with an output scoreboard.
// Padded vectors run only when NVDLA_PDP_POOL1D_PAD_EN is defined.
module tb_nv_nvdla_pdp_pool1d_lane;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  cfg_kernel_width;
    logic [3:0]  cfg_stride;
    logic [1:0]  cfg_pool_type;
    logic [12:0] cfg_line_width;
`ifdef NVDLA_PDP_POOL1D_PAD_EN
    logic [2:0]  cfg_pad_left;
    logic [2:0]  cfg_pad_right;
    logic [10:0] cfg_pad_value;
`endif
    logic        busy;

    always #5 clk = ~clk;

    nv_nvdla_pdp_pool1d_lane_if #(.PW(8))  pre_if ();
    nv_nvdla_pdp_pool1d_lane_if #(.PW(11)) out_if ();

    nv_nvdla_pdp_pool1d_lane #(.LANES(1), .DW(8), .KMAX(8)) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rstn),
        .cfg_kernel_width (cfg_kernel_width),
        .cfg_stride       (cfg_stride),
        .cfg_pool_type    (cfg_pool_type),
        .cfg_line_width   (cfg_line_width),
`ifdef NVDLA_PDP_POOL1D_PAD_EN
        .cfg_pad_left     (cfg_pad_left),
        .cfg_pad_right    (cfg_pad_right),
        .cfg_pad_value    (cfg_pad_value),
`endif
        .pre2pool         (pre_if),
        .pool2out         (out_if),
        .busy             (busy)
    );

    typedef struct packed {
        logic [2:0]        kw;
        logic [3:0]        st;
        logic [1:0]        pt;
        logic [12:0]       lw;
        logic [3:0]        n_in;
        logic [7:0][7:0]   din;
        logic [2:0]        n_out;
        logic [3:0][10:0]  dout;
        logic              stall;
    } vec_t;

    vec_t        tbl [7];
    int          n_checks = 0;
    int          n_pass = 0;
    int          out_cnt = 0;
    int          cyc = 0;
    int          stall_lo = 0;
    int          stall_hi = 0;
    logic [10:0] exp_q [$];

    function automatic vec_t mk(input int kw, input int st, input int pt, input int n,
                                input int din [8], input int nout, input int dout [4],
                                input bit stall);
        vec_t v;
        v.kw    = kw[2:0];
        v.st    = st[3:0];
        v.pt    = pt[1:0];
        v.lw    = 13'(n - 1);
        v.n_in  = 4'(n);
        v.n_out = 3'(nout);
        v.stall = stall;
        for (int i = 0; i < 8; i++) v.din[i] = din[i][7:0];
        for (int i = 0; i < 4; i++) v.dout[i] = dout[i][10:0];
        return v;
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    endtask

    // Output ready: high except inside the configured stall window.
    initial begin
        out_if.prdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            out_if.prdy = !(cyc >= stall_lo && cyc < stall_hi);
        end
    end

    // Scoreboard: a transfer is committed at the posedge following a negedge with pvld & prdy.
    initial begin
        bit          held;
        logic [10:0] hpd;
        logic [10:0] e;
        held = 1'b0;
        hpd  = '0;
        forever begin
            @(negedge clk);
            if (rstn && out_if.pvld) begin
                if (held) check(out_if.pd == hpd, "pd_stable", int'(out_if.pd), int'(hpd));
                if (out_if.prdy) begin
                    held = 1'b0;
                    out_cnt++;
                    check(exp_q.size() != 0, "out_expected", exp_q.size(), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check(out_if.pd == e, "out_pd", int'(out_if.pd), int'(e));
                    end
                end else begin
                    held = 1'b1;
                    hpd  = out_if.pd;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic drive_beat(input logic [7:0] d, output bit ok);
        int n;
        n = 0;
        pre_if.pvld = 1'b1;
        pre_if.pd   = d;
        @(negedge clk);
        while (!pre_if.prdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = pre_if.prdy;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(n < 300, "line_done_cycles", n, 300);
    endtask

    task automatic send_line(input vec_t v, input bit do_wait);
        int base;
        int acc;
        bit ok;
        cfg_kernel_width = v.kw;
        cfg_stride       = v.st;
        cfg_pool_type    = v.pt;
        cfg_line_width   = v.lw;
        base = out_cnt;
        for (int i = 0; i < int'(v.n_out); i++) exp_q.push_back(v.dout[i]);
        if (v.stall) begin
            stall_lo = cyc + 5;
            stall_hi = stall_lo + 3;
        end
        acc = 0;
        for (int b = 0; b < int'(v.n_in); b++) begin
            drive_beat(v.din[b], ok);
            if (ok) acc++;
        end
        pre_if.pvld = 1'b0;
        check(acc == int'(v.n_in), "beats_accepted", acc, int'(v.n_in));
        if (do_wait) begin
            wait_done();
            check(out_cnt - base == int'(v.n_out), "out_count", out_cnt - base, int'(v.n_out));
            check(busy == 1'b0, "busy_after_line", int'(busy), 0);
        end
    endtask

    initial begin
        int  base;
        bit  ok;
        pre_if.pvld      = 1'b0;
        pre_if.pd        = '0;
        cfg_kernel_width = '0;
        cfg_stride       = '0;
        cfg_pool_type    = '0;
        cfg_line_width   = '0;
`ifdef NVDLA_PDP_POOL1D_PAD_EN
        cfg_pad_left     = '0;
        cfg_pad_right    = '0;
        cfg_pad_value    = '0;
`endif
        // kw/st are K-1/S-1; pool type 0 sum, 1 max, 2 min, 3 sum
        tbl[0] = mk(2, 0, 1, 5, '{1, 5, 2, 7, 3, 0, 0, 0}, 3, '{5, 7, 7, 0}, 1'b0);
        tbl[1] = mk(1, 1, 0, 4, '{-1, 3, 4, 4, 0, 0, 0, 0}, 2, '{2, 8, 0, 0}, 1'b0);
        tbl[2] = mk(2, 1, 2, 7, '{9, 4, 6, -3, 8, 2, 5, 0}, 3, '{4, -3, 2, 0}, 1'b1);
        tbl[3] = mk(3, 0, 0, 3, '{1, 2, 3, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0}, 1'b0);
        tbl[4] = mk(0, 0, 3, 3, '{5, -6, 7, 0, 0, 0, 0, 0}, 3, '{5, -6, 7, 0}, 1'b0);
        tbl[5] = mk(1, 0, 1, 3, '{1, 2, 3, 0, 0, 0, 0, 0}, 2, '{2, 3, 0, 0}, 1'b0);
        tbl[6] = mk(2, 0, 0, 3, '{1, 2, 3, 0, 0, 0, 0, 0}, 3, '{5, 6, 7, 0}, 1'b0);

        repeat (3) @(negedge clk);
        check(out_if.pvld == 1'b0, "rst_pvld", int'(out_if.pvld), 0);
        check(out_if.pd == 11'd0, "rst_pd", int'(out_if.pd), 0);
        check(pre_if.prdy == 1'b0, "rst_prdy", int'(pre_if.prdy), 0);
        check(busy == 1'b0, "rst_busy", int'(busy), 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) send_line(tbl[i], 1'b1);

`ifdef NVDLA_PDP_POOL1D_PAD_EN
        cfg_pad_left  = 3'd1;
        cfg_pad_right = 3'd1;
        cfg_pad_value = 11'd2;
        send_line(tbl[6], 1'b1);
        cfg_pad_left  = 3'd0;
        cfg_pad_right = 3'd0;
        cfg_pad_value = 11'd0;
`endif

        // Back-to-back lines with no idle gap between them.
        base = out_cnt;
        send_line(tbl[4], 1'b0);
        send_line(tbl[1], 1'b0);
        wait_done();
        check(out_cnt - base == 5, "b2b_out_count", out_cnt - base, 5);

        // Reset in mid-line with a result already pending; it must not leak out.
        cfg_kernel_width = 3'd1;
        cfg_stride       = 4'd0;
        cfg_pool_type    = 2'd1;
        cfg_line_width   = 13'd4;
        drive_beat(8'd9, ok);
        check(ok, "partial_beat0", int'(ok), 1);
        drive_beat(8'd8, ok);
        check(ok, "partial_beat1", int'(ok), 1);
        rstn        = 1'b0;
        pre_if.pvld = 1'b0;
        @(negedge clk);
        check(out_if.pvld == 1'b0, "midrst_pvld", int'(out_if.pvld), 0);
        check(out_if.pd == 11'd0, "midrst_pd", int'(out_if.pd), 0);
        check(pre_if.prdy == 1'b0, "midrst_prdy", int'(pre_if.prdy), 0);
        check(busy == 1'b0, "midrst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send_line(tbl[5], 1'b1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
